// File: rtl/jtag_tap_bsr.sv
// rtl/jtag_tap_bsr.sv - JTAG TAP controller with IR, bypass, optional IDCODE and boundary-scan register
// Optional IDCODE_EN adds the 32-bit ID register and makes IDCODE the reset instruction.
module jtag_tap_bsr #(
    parameter int          IR_W       = 4,
    parameter int          BSR_LEN    = 51,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0ADD
) (
    input  logic               TCK,
    input  logic               TRST,
    input  logic               TMS,
    input  logic               TDI,
    output logic               TDO,
    output logic               TDO_en,
    input  logic [BSR_LEN-1:0] data_in,
    output logic [BSR_LEN-1:0] data_out,
    output logic [3:0]         tap_state,
    output logic [IR_W-1:0]    ir_out
);

    localparam logic [IR_W-1:0] IR_EXTEST  = '0;
    localparam logic [IR_W-1:0] IR_SAMPLE  = IR_W'(1);
    localparam logic [IR_W-1:0] IR_IDCODE  = IR_W'(2);
    localparam logic [IR_W-1:0] IR_BYPASS  = '1;
    localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(1);
`ifdef IDCODE_EN
    localparam logic [IR_W-1:0] IR_RESET   = IR_IDCODE;
`else
    localparam logic [IR_W-1:0] IR_RESET   = IR_BYPASS;
`endif

    typedef enum logic [3:0] {
        TLR     = 4'hF, RTI     = 4'hC, SEL_DR  = 4'h7, CAP_DR  = 4'h6,
        SH_DR   = 4'h2, EX1_DR  = 4'h1, PAU_DR  = 4'h3, EX2_DR  = 4'h0,
        UPD_DR  = 4'h5, SEL_IR  = 4'h4, CAP_IR  = 4'hE, SH_IR   = 4'hA,
        EX1_IR  = 4'h9, PAU_IR  = 4'hB, EX2_IR  = 4'h8, UPD_IR  = 4'hD
    } tap_state_t;

    tap_state_t         state, next_state;
    logic [IR_W-1:0]    ir_shift;
    logic [BSR_LEN-1:0] bsr_shift, bsr_upd;
    logic               bypass_reg;
    logic               is_extest, sel_bsr, sel_id, id_bit, dr_tdo;

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) state <= TLR;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            TLR:     next_state = TMS ? TLR    : RTI;
            RTI:     next_state = TMS ? SEL_DR : RTI;
            SEL_DR:  next_state = TMS ? SEL_IR : CAP_DR;
            CAP_DR:  next_state = TMS ? EX1_DR : SH_DR;
            SH_DR:   next_state = TMS ? EX1_DR : SH_DR;
            EX1_DR:  next_state = TMS ? UPD_DR : PAU_DR;
            PAU_DR:  next_state = TMS ? EX2_DR : PAU_DR;
            EX2_DR:  next_state = TMS ? UPD_DR : SH_DR;
            UPD_DR:  next_state = TMS ? SEL_DR : RTI;
            SEL_IR:  next_state = TMS ? TLR    : CAP_IR;
            CAP_IR:  next_state = TMS ? EX1_IR : SH_IR;
            SH_IR:   next_state = TMS ? EX1_IR : SH_IR;
            EX1_IR:  next_state = TMS ? UPD_IR : PAU_IR;
            PAU_IR:  next_state = TMS ? EX2_IR : PAU_IR;
            EX2_IR:  next_state = TMS ? UPD_IR : SH_IR;
            UPD_IR:  next_state = TMS ? SEL_DR : RTI;
            default: next_state = TLR;
        endcase
    end

    assign is_extest = (ir_out == IR_EXTEST);
    assign sel_bsr   = is_extest || (ir_out == IR_SAMPLE);

    // Any entry into TLR restores the reset instruction, not only TRST.
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            ir_shift <= '0;
            ir_out   <= IR_RESET;
        end else begin
            case (state)
                CAP_IR:  ir_shift <= IR_CAPTURE;
                SH_IR:   ir_shift <= {TDI, ir_shift[IR_W-1:1]};
                default: ;
            endcase
            if (next_state == TLR)    ir_out <= IR_RESET;
            else if (state == UPD_IR) ir_out <= ir_shift;
        end
    end

`ifdef IDCODE_EN
    logic [31:0] id_reg;
    assign sel_id = (ir_out == IR_IDCODE);
    assign id_bit = id_reg[0];

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) id_reg <= '0;
        else if (state == CAP_DR) id_reg <= IDCODE_VAL;
        else if (state == SH_DR && sel_id) id_reg <= {TDI, id_reg[31:1]};
    end
`else
    assign sel_id = 1'b0;
    assign id_bit = 1'b0;
`endif

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            bsr_shift  <= '0;
            bsr_upd    <= '0;
            bypass_reg <= 1'b0;
        end else begin
            case (state)
                CAP_DR: begin
                    bsr_shift  <= data_in;
                    bypass_reg <= 1'b0;
                end
                SH_DR: begin
                    if (sel_bsr) bsr_shift <= {TDI, bsr_shift[BSR_LEN-1:1]};
                    if (!sel_bsr && !sel_id) bypass_reg <= TDI;
                end
                UPD_DR: if (sel_bsr) bsr_upd <= bsr_shift;
                default: ;
            endcase
        end
    end

    assign dr_tdo = sel_bsr ? bsr_shift[0] : (sel_id ? id_bit : bypass_reg);

    // Falling-edge launch gives the receiving device a half cycle of setup.
    always_ff @(negedge TCK or posedge TRST) begin
        if (TRST) begin
            TDO    <= 1'b0;
            TDO_en <= 1'b0;
        end else begin
            case (state)
                SH_DR: begin
                    TDO    <= dr_tdo;
                    TDO_en <= 1'b1;
                end
                SH_IR: begin
                    TDO    <= ir_shift[0];
                    TDO_en <= 1'b1;
                end
                default: begin
                    TDO    <= 1'b0;
                    TDO_en <= 1'b0;
                end
            endcase
        end
    end

    assign data_out  = is_extest ? bsr_upd : data_in;
    assign tap_state = state;

endmodule

// File: doc/jtag_tap_bsr.md
Name: jtag_tap_bsr

Overview:
Parametrised JTAG test access port: a full 16-state TAP controller, an IR_W-bit instruction register, a bypass register and a BSR_LEN-cell boundary-scan register (BSR) with capture/shift/update stages. It sits between the board-level TCK/TMS/TDI/TDO pins and a datapath core, for example the ripple adder with its a, b, cin, sel, sum and co pins. It generalises the earlier fixed-length chain with configurable IR width and chain length, decoded EXTEST, SAMPLE/PRELOAD, BYPASS and IDCODE instructions, and a TDO output enable.

Parameters:
IR_W, 4, instruction register width (>=2)
BSR_LEN, 51, boundary cells (3*16 data pins + cin + sel + co)
IDCODE_VAL, 32'h1000_0ADD, 32-bit device ID; bit 0 must be 1

Ports:
TCK  input  1  test clock; the only clock
TRST  input  1  asynchronous active-high reset
TMS  input  1  mode select, sampled on TCK rising edge
TDI  input  1  serial data in, sampled on TCK rising edge
TDO  output  1  serial data out, changes on TCK falling edge
TDO_en  output  1  high while in Shift-DR/Shift-IR, on the same falling-edge timing as TDO
data_in  input  BSR_LEN  functional values from pads/core
data_out  output  BSR_LEN  values driven to core/pads
tap_state  output  4  current TAP state code
ir_out  output  IR_W  active instruction

Behaviour:
- One clock, TCK. Reset is asynchronous and active-high: TRST.
- Reset values:
  - tap_state = TLR (4'hF).
  - ir_out = IDCODE (BYPASS when the macro is absent).
  - BSR shift and update stages = 0.
  - bypass reg = 0.
  - TDO = 0, TDO_en = 0.
- FSM state codes (standard encoding): TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauseDR 3, Ex2DR 0, UpdDR 5, SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauseIR B, Ex2IR 8, UpdIR D.
- FSM transitions follow IEEE 1149.1 on the TMS value at the rising edge. Five TCKs with TMS=1 reach TLR from any state.
- Entering TLR (by TMS or TRST) reloads ir_out with its reset value.
- Instructions (IR_W=4): EXTEST 0000, SAMPLE/PRELOAD 0001, IDCODE 0010, BYPASS all ones. Any undefined code selects BYPASS.
- CapIR: IR shift reg loads {0..0,01}.
- ShIR: IR shifts right, TDI enters the MSB, TDO = LSB.
- UpdIR: ir_out <= IR shift reg.
- DR selection by ir_out:
  - EXTEST and SAMPLE: BSR.
  - IDCODE: 32-bit ID register.
  - Otherwise: 1-bit bypass.
- CapDR:
  - BSR shift stage <= data_in.
  - ID reg <= IDCODE_VAL.
  - Bypass <= 0.
- ShDR: selected register shifts toward bit 0, TDI enters the top bit, TDO = bit 0. BSR length is exactly BSR_LEN, so a bit entering at TDI emerges at TDO after BSR_LEN shifts.
- UpdDR: BSR update stage <= BSR shift stage, only for EXTEST or SAMPLE. Update stage holds in all other states.
- data_out:
  - EXTEST: BSR update stage.
  - Otherwise: data_in, combinational pass-through, zero latency.
- TDO and TDO_en are registered on the TCK falling edge. Outside shift states TDO = 0 and TDO_en = 0.
- Pause/Exit2 states hold shift contents unchanged; a shift resumes seamlessly from Ex2 -> Shift.
- TRST mid-shift: all state is lost immediately, data_out reverts to data_in (ir_out is no longer EXTEST).
- A changed instruction takes effect only at UpdIR. Shifting the IR does not disturb data_out.

Optional Feature:
- IDCODE_EN defined:
  - 32-bit ID register and IDCODE decode present.
  - Reset/TLR instruction = IDCODE.
- Absent:
  - No ID register.
  - Code 0010 decodes as BYPASS.
  - Reset/TLR instruction = BYPASS, so a DR scan after reset yields a single 0 capture bit followed by the TDI data.

Test Plan:
1. TRST=1 pulse, then 5 TCKs with TMS=1 from RTI -> tap_state=F, ir_out=0010 (IDCODE_EN), TDO_en=0.
2. After reset, do a DR scan: shift 32 bits -> TDO sequence LSB-first equals 32'h1000_0ADD; with the macro off, the first bit is 0 (bypass).
3. IR scan shifting 1111 -> TDO shows 1,0,0,0 (captured 0001). Then a DR scan of pattern 1,0,1 -> appears at TDO delayed by exactly one bit.
4. SAMPLE: data_in = 51'h5_5555_AAAA_FFFF, enter CapDR, shift 51 bits -> TDO emits those bits LSB-first. data_out equals data_in throughout.
5. PRELOAD then EXTEST: shift a=0x1234 pattern during SAMPLE, UpdDR, then load EXTEST -> data_out equals the preloaded pattern immediately after UpdIR, independent of data_in.
6. Assert TRST in ShDR mid-EXTEST -> tap_state=F the same cycle, data_out==data_in, TDO=0.
